laser_frame_driver: RTL and testbench
=====================================

# laser_frame_driver

Stimulus/checker block on the far side of the laser-coverage engine's point-stream interface. It fetches 40 points per frame from a point ROM and streams them on X/Y in the engine's one-point-per-cycle read order. It waits for the engine's DONE pulse, captures C1X/C1Y/C2X/C2Y, compares them against a golden ROM entry, and keeps pass/fail counts over NUM_FRAMES frames.

## Interface
- NUM_FRAMES, 6: frames per run (1..12).
- POINTS, 40: points per frame; fixed by the engine protocol.
- TIMEOUT, 100000: maximum WAIT cycles before a frame is declared lost.
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- START  in  1  one-cycle pulse; begins a run; ignored unless IDLE or FIN.
- PT_ADDR  out  9  point ROM address = frame*POINTS + idx.
- PT_X, PT_Y  in  4 each  point ROM data; combinational, valid in the same cycle as PT_ADDR.
- GOLD_ADDR  out  4  golden ROM address = current frame.
- GOLD  in  16  {C1X,C1Y,C2X,C2Y} expected; combinational.
- LASER_RST  out  1  active-high reset to the engine.
- X, Y  out  4 each  point stream to the engine.
- DONE  in  1  engine result strobe.
- C1X, C1Y, C2X, C2Y  in  4 each  engine result; valid only while DONE=1.
- BUSY  out  1  run in progress.
- FIN  out  1  high while in FIN state.
- PASS_CNT, FAIL_CNT  out  4 each  frame tallies.
- PROTO_ERR  out  1  sticky; DONE seen outside WAIT.

## Operation
- States: IDLE, STREAM, WAIT, RESTART, FIN.
- Reset (RST_N=0 at edge): state IDLE; LASER_RST=1; X=Y=0; frame=0; idx=0; wait counter=0; PASS_CNT=FAIL_CNT=0; PROTO_ERR=0; BUSY=0; FIN=0.
- IDLE/FIN + START: clear counts, frame, and PROTO_ERR; LASER_RST<=0; X/Y<=point(frame 0, idx 0); idx<=1; go to STREAM; BUSY<=1.
- STREAM: each edge, X/Y<=point(frame, idx) and idx++. The edge that would load idx=POINTS instead drives X/Y<=0 and goes to WAIT with wait counter=0. Point k is therefore on X/Y for exactly one cycle: cycle k after the launching edge.
- WAIT, DONE=1: compare. Match if {C1,C2}==GOLD or, swapped, {C2X,C2Y,C1X,C1Y}==GOLD; increment PASS_CNT on match, else FAIL_CNT. Counters saturate at 15. If frame<NUM_FRAMES-1, frame++ and launch the next frame on the same edge (X/Y<=point(frame+1, 0), idx<=1, go to STREAM). The engine returns to its read phase on this edge, so no gap is allowed. Otherwise LASER_RST<=1 and go to FIN with BUSY<=0.
- WAIT, DONE=0: wait counter++. On reaching TIMEOUT-1: FAIL_CNT++, LASER_RST<=1, go to RESTART.
- RESTART (one cycle): if frames remain, frame++, LASER_RST<=0, launch next frame as above. Otherwise go to FIN.
- DONE=1 in IDLE, STREAM, RESTART or FIN sets PROTO_ERR. The state machine ignores it.
- START outside IDLE/FIN is ignored.
- RST_N low mid-run aborts at that edge and returns everything to reset values.
- FIN: outputs hold; LASER_RST=1 until the next START.

## Timing
- All outputs are registered.
- PT_ADDR and GOLD_ADDR are combinational from the frame/idx registers; the ROMs are asynchronous.
- Launch edge E: LASER_RST falls and point 0 appears. The engine samples point k at edge E+1+k.
- Last point is on X/Y during cycle E+39 through E+40; WAIT is entered at edge E+40.
- Compare latency: 0. Counts update on the edge that samples DONE=1.
- The next frame's point 0 is driven in the cycle after the DONE cycle.
- Timeout: the frame is failed at edge E+40+TIMEOUT.
- After a timeout, the engine sees exactly one LASER_RST-high cycle before the next launch.

## Test plan
- Reset then START, behavioural engine model returns the golden answer for all 6 frames -> X/Y match the ROM cycle-exactly (point k at E+1+k); PASS_CNT=6; FAIL_CNT=0; FIN=1; LASER_RST=1.
- Model returns C1/C2 swapped on frame 2 -> that frame is counted as a pass; PASS_CNT=6.
- Model returns C1X off by 1 on frames 0 and 5 -> PASS_CNT=4, FAIL_CNT=2.
- Model never asserts DONE on frame 3 with TIMEOUT=200 -> FAIL_CNT=1 at WAIT+200 cycles; one-cycle LASER_RST pulse; frame 4 launches; final PASS_CNT=5.
- DONE forced high during STREAM idx 10 -> PROTO_ERR=1; streaming continues unchanged; PROTO_ERR clears on the next START.
- RST_N low during WAIT of frame 1, then START -> all counters restart from 0; frame 0 is re-streamed from point 0.

Source files
------------

// File: rtl/laser_frame_driver_if.sv
// Point-stream / result link between the frame driver and the laser-coverage engine.
interface laser_frame_driver_if;
    logic       laser_rst;
    logic [3:0] x;
    logic [3:0] y;
    logic       done;
    logic [3:0] c1x;
    logic [3:0] c1y;
    logic [3:0] c2x;
    logic [3:0] c2y;

    modport master (
        output laser_rst, x, y,
        input  done, c1x, c1y, c2x, c2y
    );

    modport slave (
        input  laser_rst, x, y,
        output done, c1x, c1y, c2x, c2y
    );
endinterface

// File: rtl/laser_frame_driver.sv
// Streams ROM point frames into the laser-coverage engine, checks each result
// against a golden ROM and tallies pass/fail over a run of frames.
module laser_frame_driver #(
    parameter int NUM_FRAMES = 6,
    parameter int POINTS     = 40,
    parameter int TIMEOUT    = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [8:0]           pt_addr,
    input  logic [3:0]           pt_x,
    input  logic [3:0]           pt_y,
    output logic [3:0]           gold_addr,
    input  logic [15:0]          gold,
    laser_frame_driver_if.master eng,
    output logic                 busy,
    output logic                 fin,
    output logic [3:0]           pass_cnt,
    output logic [3:0]           fail_cnt,
    output logic                 proto_err
);
    localparam int             WCW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0]     IDX_END    = 6'(POINTS);
    localparam logic [3:0]     LAST_FRAME = 4'(NUM_FRAMES - 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, STREAM, WAIT, RESTART, FIN} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     frame_reg, frame_next;
    logic [5:0]     idx_reg, idx_next;
    logic [WCW-1:0] wait_reg, wait_next;
    logic [3:0]     x_reg, x_next;
    logic [3:0]     y_reg, y_next;
    logic           laser_rst_reg, laser_rst_next;
    logic           busy_reg, busy_next;
    logic           fin_reg, fin_next;
    logic [3:0]     pass_reg, pass_next;
    logic [3:0]     fail_reg, fail_next;
    logic           proto_reg, proto_next;

    logic [3:0]     fetch_frame;
    logic [5:0]     fetch_idx;
    logic           last_frame;
    logic           match;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign last_frame = (frame_reg == LAST_FRAME);
    assign match = ({eng.c1x, eng.c1y, eng.c2x, eng.c2y} == gold) ||
                   ({eng.c2x, eng.c2y, eng.c1x, eng.c1y} == gold);

    // Outside STREAM the ROM is pre-addressed at point 0 of whichever frame
    // the next launch will use, so a launch never costs a fetch cycle.
    always_comb begin
        fetch_frame = 4'd0;
        fetch_idx   = 6'd0;
        case (state_reg)
            STREAM: begin
                fetch_frame = frame_reg;
                fetch_idx   = idx_reg;
            end
            WAIT, RESTART: fetch_frame = frame_reg + 4'd1;
            default: ;
        endcase
    end

    assign pt_addr   = 9'(fetch_frame) * 9'(POINTS) + 9'(fetch_idx);
    assign gold_addr = frame_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            frame_reg     <= 4'd0;
            idx_reg       <= 6'd0;
            wait_reg      <= '0;
            x_reg         <= 4'd0;
            y_reg         <= 4'd0;
            laser_rst_reg <= 1'b1;
            busy_reg      <= 1'b0;
            fin_reg       <= 1'b0;
            pass_reg      <= 4'd0;
            fail_reg      <= 4'd0;
            proto_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_reg     <= frame_next;
            idx_reg       <= idx_next;
            wait_reg      <= wait_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            laser_rst_reg <= laser_rst_next;
            busy_reg      <= busy_next;
            fin_reg       <= fin_next;
            pass_reg      <= pass_next;
            fail_reg      <= fail_next;
            proto_reg     <= proto_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, FIN: if (start) state_next = STREAM;
            STREAM:    if (idx_reg == IDX_END) state_next = WAIT;
            WAIT: begin
                if (eng.done)
                    state_next = last_frame ? FIN : STREAM;
                else if (wait_reg == WAIT_LAST)
                    state_next = RESTART;
            end
            RESTART:   state_next = last_frame ? FIN : STREAM;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        frame_next     = frame_reg;
        idx_next       = idx_reg;
        wait_next      = wait_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        laser_rst_next = laser_rst_reg;
        busy_next      = busy_reg;
        fin_next       = fin_reg;
        pass_next      = pass_reg;
        fail_next      = fail_reg;
        proto_next     = proto_reg;

        case (state_reg)
            IDLE, FIN: begin
                if (start) begin
                    frame_next = 4'd0;
                    pass_next  = 4'd0;
                    fail_next  = 4'd0;
                    proto_next = 1'b0;
                    busy_next  = 1'b1;
                    fin_next   = 1'b0;
                end
            end
            STREAM: begin
                if (idx_reg == IDX_END) begin
                    x_next    = 4'd0;
                    y_next    = 4'd0;
                    wait_next = '0;
                end
            end
            WAIT: begin
                if (eng.done) begin
                    if (match)
                        pass_next = sat_inc(pass_reg);
                    else
                        fail_next = sat_inc(fail_reg);
                    if (!last_frame)
                        frame_next = frame_reg + 4'd1;
                end else if (wait_reg == WAIT_LAST) begin
                    fail_next      = sat_inc(fail_reg);
                    laser_rst_next = 1'b1;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            RESTART: begin
                if (!last_frame)
                    frame_next = frame_reg + 4'd1;
            end
            default: ;
        endcase

        // Every edge that lands in STREAM puts the addressed point on X/Y.
        if (state_next == STREAM) begin
            x_next         = pt_x;
            y_next         = pt_y;
            idx_next       = (state_reg == STREAM) ? idx_reg + 6'd1 : 6'd1;
            laser_rst_next = 1'b0;
        end

        if (state_next == FIN && state_reg != FIN) begin
            laser_rst_next = 1'b1;
            busy_next      = 1'b0;
            fin_next       = 1'b1;
        end

        if (eng.done && state_reg != WAIT)
            proto_next = 1'b1;
    end

    assign eng.laser_rst = laser_rst_reg;
    assign eng.x         = x_reg;
    assign eng.y         = y_reg;
    assign busy          = busy_reg;
    assign fin           = fin_reg;
    assign pass_cnt      = pass_reg;
    assign fail_cnt      = fail_reg;
    assign proto_err     = proto_reg;
endmodule

// File: tb/tb_laser_frame_driver.sv
// Bench for laser_frame_driver: ROM models, a behavioural engine that checks the
// point stream cycle by cycle, and a table of whole-run scenarios.
module tb_laser_frame_driver;
    localparam int NF  = 6;
    localparam int PTS = 40;
    localparam int TO  = 200;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  pt_addr;
    logic [3:0]  pt_x, pt_y;
    logic [3:0]  gold_addr;
    logic [15:0] gold;
    logic        busy, fin, proto_err;
    logic [3:0]  pass_cnt, fail_cnt;

    laser_frame_driver_if eif ();

    laser_frame_driver #(.NUM_FRAMES(NF), .POINTS(PTS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pt_addr(pt_addr), .pt_x(pt_x), .pt_y(pt_y),
        .gold_addr(gold_addr), .gold(gold),
        .eng(eif),
        .busy(busy), .fin(fin),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_x(input int a);
        return 4'(a ^ (a >> 4));
    endfunction
    function automatic logic [3:0] rom_y(input int a);
        return 4'((a * 5 + 3) >> 1);
    endfunction
    function automatic logic [15:0] gold_of(input int f);
        return {4'(f + 1), 4'(f * 3), 4'(15 - f), 4'(f ^ 5)};
    endfunction

    assign pt_x = rom_x(int'(pt_addr));
    assign pt_y = rom_y(int'(pt_addr));
    assign gold = gold_of(int'(gold_addr));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0] swap_m;
        logic [11:0] off_m;
        logic [11:0] nor_m;
        int          force_idx;
        bit          mid_start;
        int          exp_pass;
        int          exp_fail;
        bit          exp_proto;
    } vec_t;

    // Engine model state
    bit          model_en = 1'b0;
    logic [11:0] swap_m, off_m, nor_m;
    int          force_idx;
    int          ef, rd_cnt, lat_cnt, gap_cnt, to_gap, to_pulse;
    int          pts_seen, model_pass, model_fail;
    bit          real_done, forced, pending_to, counting_gap, pulse_meas;

    initial begin
        logic [15:0] g;
        eif.done = 1'b0;
        eif.c1x = 4'd0; eif.c1y = 4'd0; eif.c2x = 4'd0; eif.c2y = 4'd0;
        forever begin
            @(negedge clk);
            if (!model_en) begin
                eif.done = 1'b0;
            end else begin
                if (forced) begin
                    forced   = 1'b0;
                    eif.done = 1'b0;
                    check("proto_err_after_stray_done", proto_err, 1);
                end
                if (counting_gap) gap_cnt++;
                if (real_done) begin
                    real_done = 1'b0;
                    eif.done  = 1'b0;
                    ef++;
                    rd_cnt = 0;
                    check("pass_after_done", pass_cnt, model_pass);
                    check("fail_after_done", fail_cnt, model_fail);
                end
                if (eif.laser_rst) begin
                    if (counting_gap) begin
                        counting_gap = 1'b0;
                        to_gap       = gap_cnt;
                        model_fail++;
                        check("fail_at_timeout", fail_cnt, model_fail);
                        pulse_meas = 1'b1;
                        to_pulse   = 0;
                    end
                    if (pending_to) begin
                        pending_to = 1'b0;
                        ef++;
                    end
                    if (pulse_meas) to_pulse++;
                    rd_cnt = 0;
                end else begin
                    pulse_meas = 1'b0;
                    if (rd_cnt < PTS) begin
                        tests++;
                        if (eif.x !== rom_x(ef * PTS + rd_cnt) || eif.y !== rom_y(ef * PTS + rd_cnt)) begin
                            fails++;
                            $display("FAIL stream f%0d p%0d: got x=%0d y=%0d expected x=%0d y=%0d",
                                     ef, rd_cnt, eif.x, eif.y,
                                     rom_x(ef * PTS + rd_cnt), rom_y(ef * PTS + rd_cnt));
                        end
                        pts_seen++;
                        if (ef == 0 && rd_cnt == force_idx) begin
                            eif.done = 1'b1;
                            forced   = 1'b1;
                        end
                        rd_cnt++;
                        if (rd_cnt == PTS) begin
                            lat_cnt = 0;
                            if (nor_m[ef]) begin
                                pending_to   = 1'b1;
                                counting_gap = 1'b1;
                                gap_cnt      = 0;
                            end
                        end
                    end else if (!pending_to) begin
                        lat_cnt++;
                        if (lat_cnt == LAT) begin
                            g = gold_of(ef);
                            if (swap_m[ef]) g = {g[7:0], g[15:8]};
                            if (off_m[ef]) g[15:12] = g[15:12] + 4'd1;
                            {eif.c1x, eif.c1y, eif.c2x, eif.c2y} = g;
                            eif.done  = 1'b1;
                            real_done = 1'b1;
                            if (off_m[ef]) model_fail++;
                            else           model_pass++;
                        end
                    end
                end
            end
        end
    end

    task automatic launch(input vec_t v);
        @(posedge clk); #2;
        swap_m = v.swap_m; off_m = v.off_m; nor_m = v.nor_m; force_idx = v.force_idx;
        ef = 0; rd_cnt = 0; lat_cnt = 0; gap_cnt = 0; to_gap = -1; to_pulse = 0;
        pts_seen = 0; model_pass = 0; model_fail = 0;
        real_done = 1'b0; forced = 1'b0; pending_to = 1'b0;
        counting_gap = 1'b0; pulse_meas = 1'b0;
        model_en = 1'b1;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("launch_laser_rst", eif.laser_rst, 0);
        check("launch_busy", busy, 1);
        check("launch_proto_clear", proto_err, 0);
        check("launch_counts_clear", {pass_cnt, fail_cnt}, 0);
    endtask

    task automatic finish_check(input vec_t v);
        int cyc = 0;
        while (fin !== 1'b1 && cyc < 4000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("fin_reached", fin, 1);
        check("final_pass", pass_cnt, v.exp_pass);
        check("final_fail", fail_cnt, v.exp_fail);
        check("final_laser_rst", eif.laser_rst, 1);
        check("final_busy", busy, 0);
        check("final_proto", proto_err, v.exp_proto);
        check("points_streamed", pts_seen, NF * PTS);
        if (v.nor_m != 12'h0) begin
            check("timeout_gap", to_gap, TO + 1);
            check("timeout_rst_pulse", to_pulse, 1);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vec_t vr;
        int   cyc;
        vecs[0] = '{12'h000, 12'h000, 12'h000, -1, 1'b1, 6, 0, 1'b0};
        vecs[1] = '{12'h004, 12'h000, 12'h000, -1, 1'b0, 6, 0, 1'b0};
        vecs[2] = '{12'h000, 12'h021, 12'h000, -1, 1'b0, 4, 2, 1'b0};
        vecs[3] = '{12'h000, 12'h000, 12'h008, -1, 1'b0, 5, 1, 1'b0};
        vecs[4] = '{12'h000, 12'h000, 12'h000, 10, 1'b0, 6, 0, 1'b1};
        vecs[5] = '{12'h000, 12'h000, 12'h000, -1, 1'b0, 6, 0, 1'b0};
        vecs[6] = '{12'h03F, 12'h002, 12'h000, -1, 1'b0, 5, 1, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        force_idx = -1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_laser_rst", eif.laser_rst, 1);
        check("rst_x", eif.x, 0);
        check("rst_y", eif.y, 0);
        check("rst_busy", busy, 0);
        check("rst_fin", fin, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_proto", proto_err, 0);
        check("rst_pt_addr", pt_addr, 0);
        check("rst_gold_addr", gold_addr, 0);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i]);
            if (vecs[i].mid_start) begin
                repeat (20) @(posedge clk);
                #2 start = 1'b1;
                @(posedge clk); #2;
                start = 1'b0;
            end
            finish_check(vecs[i]);
            $display("[TB] vector %0d: pass=%0d fail=%0d proto=%0d", i, pass_cnt, fail_cnt, proto_err);
        end

        // Reset while waiting for frame 1's result, then a clean run.
        vr = '{12'h000, 12'h000, 12'h002, -1, 1'b0, 6, 0, 1'b0};
        launch(vr);
        cyc = 0;
        while (!(ef == 1 && rd_cnt == PTS) && cyc < 1000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("reached_wait_frame1", (ef == 1 && rd_cnt == PTS), 1);
        repeat (3) @(posedge clk);
        #2;
        check("pre_reset_pass", pass_cnt, 1);
        model_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("midrst_laser_rst", eif.laser_rst, 1);
        check("midrst_busy", busy, 0);
        check("midrst_pass", pass_cnt, 0);
        check("midrst_gold_addr", gold_addr, 0);
        check("midrst_x", eif.x, 0);
        vr = '{12'h000, 12'h000, 12'h000, -1, 1'b0, 6, 0, 1'b0};
        launch(vr);
        finish_check(vr);
        $display("[TB] post-reset run: pass=%0d fail=%0d", pass_cnt, fail_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
